// File: rtl/mul_operand_issuer.sv
// Operand-pair issuer for a streaming multiplier: splits each {a, b} pair onto the
// A/B channels, accumulates returned products and emits one sum per tlast packet.
module mul_operand_issuer #(
  parameter int DATA_W = 2,
  parameter int LEN_W  = 4,
  localparam int PROD_W = 2 * DATA_W,
  localparam int ACC_W  = 2 * DATA_W + LEN_W
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [PROD_W-1:0] s_pair_tdata,
  input  logic              s_pair_tlast,
  input  logic              s_pair_tvalid,
  output logic              s_pair_tready,
  output logic [DATA_W-1:0] m_a_tdata,
  output logic              m_a_tvalid,
  input  logic              m_a_tready,
  output logic [DATA_W-1:0] m_b_tdata,
  output logic              m_b_tvalid,
  input  logic              m_b_tready,
  input  logic [PROD_W-1:0] s_result_tdata,
  input  logic              s_result_tvalid,
  output logic              s_result_tready,
  output logic [ACC_W-1:0]  m_sum_tdata,
  output logic              m_sum_tvalid,
  input  logic              m_sum_tready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, SEND} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic               last_q, last_d;
  logic               a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [ACC_W-1:0]   acc_q, acc_d, sum_q, sum_d;
  logic               sum_valid_q, sum_valid_d;
  logic               a_fire, b_fire;
  logic [ACC_W-1:0]   acc_sum;

  assign a_fire  = a_valid_q && m_a_tready;
  assign b_fire  = b_valid_q && m_b_tready;
  assign acc_sum = acc_q + {{LEN_W{1'b0}}, s_result_tdata};

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    last_d      = last_q;
    a_valid_d   = a_valid_q;
    b_valid_d   = b_valid_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    case (state_q)
      IDLE: begin
        if (s_pair_tvalid) begin
          a_d       = s_pair_tdata[PROD_W-1:DATA_W];
          b_d       = s_pair_tdata[DATA_W-1:0];
          last_d    = s_pair_tlast;
          a_valid_d = 1'b1;
          b_valid_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        // A cleared valid doubles as that channel's "sent" flag.
        if (a_fire) a_valid_d = 1'b0;
        if (b_fire) b_valid_d = 1'b0;
        if ((!a_valid_q || a_fire) && (!b_valid_q || b_fire)) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (s_result_tvalid) begin
          acc_d = acc_sum;
          if (last_q) begin
            sum_d       = acc_sum;
            sum_valid_d = 1'b1;
            state_d     = SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      SEND: begin
        if (m_sum_tready) begin
          acc_d       = '0;
          sum_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      last_q      <= 1'b0;
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      last_q      <= last_d;
      a_valid_q   <= a_valid_d;
      b_valid_q   <= b_valid_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign s_pair_tready   = (state_q == IDLE);
  assign s_result_tready = (state_q == WAIT_RES);
  assign m_a_tdata       = a_q;
  assign m_a_tvalid      = a_valid_q;
  assign m_b_tdata       = b_q;
  assign m_b_tvalid      = b_valid_q;
  assign m_sum_tdata     = sum_q;
  assign m_sum_tvalid    = sum_valid_q;

endmodule

// File: tb/tb_mul_operand_issuer.sv
// Scoreboard bench for mul_operand_issuer with a 3-cycle multiplier model.
module tb_mul_operand_issuer;
  localparam int DATA_W = 2;
  localparam int LEN_W  = 4;
  localparam int ACC_W  = 2 * DATA_W + LEN_W;

  logic              clk = 1'b0;
  logic              arst_n;
  logic [2*DATA_W-1:0] s_pair_tdata;
  logic              s_pair_tlast, s_pair_tvalid, s_pair_tready;
  logic [DATA_W-1:0] m_a_tdata, m_b_tdata;
  logic              m_a_tvalid, m_a_tready, m_b_tvalid, m_b_tready;
  logic [2*DATA_W-1:0] s_result_tdata;
  logic              s_result_tvalid, s_result_tready;
  logic [ACC_W-1:0]  m_sum_tdata;
  logic              m_sum_tvalid, m_sum_tready;

  mul_operand_issuer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .arst_n(arst_n),
    .s_pair_tdata(s_pair_tdata), .s_pair_tlast(s_pair_tlast),
    .s_pair_tvalid(s_pair_tvalid), .s_pair_tready(s_pair_tready),
    .m_a_tdata(m_a_tdata), .m_a_tvalid(m_a_tvalid), .m_a_tready(m_a_tready),
    .m_b_tdata(m_b_tdata), .m_b_tvalid(m_b_tvalid), .m_b_tready(m_b_tready),
    .s_result_tdata(s_result_tdata), .s_result_tvalid(s_result_tvalid),
    .s_result_tready(s_result_tready),
    .m_sum_tdata(m_sum_tdata), .m_sum_tvalid(m_sum_tvalid), .m_sum_tready(m_sum_tready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int a_cnt = 0, b_cnt = 0, exp_pairs = 0;
  logic [DATA_W-1:0] exp_a_q[$];
  logic [DATA_W-1:0] exp_b_q[$];
  logic [ACC_W-1:0]  exp_sum_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Multiplier model: captures A and B independently, answers after ~3 cycles.
  logic got_a = 0, got_b = 0, busy = 0;
  logic [DATA_W-1:0] ma = '0, mb = '0;
  int cnt = 0;
  always begin
    logic a_f, b_f, r_f;
    logic [DATA_W-1:0] a_v, b_v;
    @(negedge clk);
    a_f = m_a_tvalid && m_a_tready;
    b_f = m_b_tvalid && m_b_tready;
    r_f = s_result_tvalid && s_result_tready;
    a_v = m_a_tdata;
    b_v = m_b_tdata;
    @(posedge clk);
    #1;
    if (!arst_n) begin
      got_a = 0; got_b = 0; busy = 0; cnt = 0;
      s_result_tvalid = 1'b0;
    end else begin
      if (a_f) begin got_a = 1; ma = a_v; end
      if (b_f) begin got_b = 1; mb = b_v; end
      if (r_f) begin s_result_tvalid = 1'b0; busy = 0; end
      if (busy && !s_result_tvalid) begin
        if (cnt > 0) cnt--;
        else s_result_tvalid = 1'b1;
      end
      if (got_a && got_b && !busy) begin
        busy = 1; cnt = 2;
        s_result_tdata = ma * mb;
        got_a = 0; got_b = 0;
      end
    end
  end

  // Monitor: pops expected operands and sums whenever a handshake is about to complete.
  always @(negedge clk) begin
    if (arst_n) begin
      if (m_a_tvalid && m_a_tready) begin
        a_cnt++;
        if (exp_a_q.size() == 0) check("a_unexpected", 1, 0);
        else check("a_data", m_a_tdata, exp_a_q.pop_front());
      end
      if (m_b_tvalid && m_b_tready) begin
        b_cnt++;
        if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
        else check("b_data", m_b_tdata, exp_b_q.pop_front());
      end
      if (m_sum_tvalid && m_sum_tready) begin
        $display("[TB] sum out %0d", m_sum_tdata);
        if (exp_sum_q.size() == 0) check("sum_unexpected", 1, 0);
        else check("sum_data", m_sum_tdata, exp_sum_q.pop_front());
      end
    end
  end

  task automatic send_pair(input int a, input int b, input bit last);
    bit done = 0;
    exp_a_q.push_back(DATA_W'(a));
    exp_b_q.push_back(DATA_W'(b));
    exp_pairs++;
    s_pair_tdata  = {DATA_W'(a), DATA_W'(b)};
    s_pair_tlast  = last;
    s_pair_tvalid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (s_pair_tready) done = 1;
    end
    @(posedge clk);
    #1;
    s_pair_tvalid = 1'b0;
    s_pair_tlast  = 1'b0;
    $display("[TB] pair a=%0d b=%0d last=%0d", a, b, last);
    if (!done) check("pair_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (exp_sum_q.size() == 0 && s_pair_tready) done = 1;
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_n = 1'b0;
    s_pair_tdata = '0; s_pair_tlast = 0; s_pair_tvalid = 0;
    m_a_tready = 1; m_b_tready = 1; m_sum_tready = 1;
    s_result_tvalid = 0; s_result_tdata = '0;
    #3;
    check("rst_pair_tready", s_pair_tready, 1);
    check("rst_a_valid", m_a_tvalid, 0);
    check("rst_b_valid", m_b_tvalid, 0);
    check("rst_a_data", m_a_tdata, 0);
    check("rst_b_data", m_b_tdata, 0);
    check("rst_result_tready", s_result_tready, 0);
    check("rst_sum_valid", m_sum_tvalid, 0);
    check("rst_sum_data", m_sum_tdata, 0);
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_pair_tready", s_pair_tready, 1);

    // 3*3 + 2*1 + 1*3 = 14
    exp_sum_q.push_back(8'd14);
    send_pair(3, 3, 0);
    send_pair(2, 1, 0);
    send_pair(1, 3, 1);
    wait_drain();

    // A channel stalled while B completes
    m_a_tready = 0;
    exp_sum_q.push_back(8'd6);
    send_pair(2, 3, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_a_valid", m_a_tvalid, 1);
      check("stall_a_data", m_a_tdata, 2);
      if (i > 0) check("stall_b_dropped", m_b_tvalid, 0);
    end
    @(posedge clk);
    #1;
    m_a_tready = 1;
    wait_drain();

    // Sum backpressure
    m_sum_tready = 0;
    exp_sum_q.push_back(8'd6);
    send_pair(3, 2, 1);
    begin
      bit seen = 0;
      for (int n = 0; n < 50 && !seen; n++) begin
        @(negedge clk);
        if (m_sum_tvalid) seen = 1;
      end
      check("sum_valid_seen", seen, 1);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_sum_valid", m_sum_tvalid, 1);
      check("bp_sum_data", m_sum_tdata, 6);
      check("bp_pair_tready", s_pair_tready, 0);
    end
    @(posedge clk);
    #1;
    m_sum_tready = 1;
    wait_drain();

    // Wrap: 29 * 9 = 261 -> 5 mod 256
    exp_sum_q.push_back(8'd5);
    for (int i = 0; i < 29; i++) send_pair(3, 3, i == 28);
    wait_drain();

    // Reset mid-packet in WAIT_RES
    send_pair(2, 3, 0);
    begin
      bit seen = 0;
      for (int n = 0; n < 50 && !seen; n++) begin
        @(negedge clk);
        if (s_result_tready) seen = 1;
      end
      check("wait_res_seen", seen, 1);
    end
    @(posedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    check("mid_rst_a_valid", m_a_tvalid, 0);
    check("mid_rst_b_valid", m_b_tvalid, 0);
    check("mid_rst_sum_valid", m_sum_tvalid, 0);
    check("mid_rst_pair_tready", s_pair_tready, 1);
    check("mid_rst_result_tready", s_result_tready, 0);
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(negedge clk);
    check("post_rst_sum_valid", m_sum_tvalid, 0);
    @(posedge clk);
    #1;
    exp_sum_q.push_back(8'd1);
    send_pair(1, 1, 1);
    wait_drain();

    // Back-to-back packets: accumulator cleared between them
    exp_sum_q.push_back(8'd4);
    exp_sum_q.push_back(8'd5);
    send_pair(2, 2, 1);
    send_pair(1, 2, 0);
    send_pair(3, 1, 1);
    wait_drain();

    repeat (5) @(negedge clk);
    check("a_handshakes", a_cnt, exp_pairs);
    check("b_handshakes", b_cnt, exp_pairs);
    check("sum_queue_empty", exp_sum_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end
endmodule
